// File: rtl/switch_debouncer_if.sv
// Switch-vector bundle between the raw slide switches and the debounced consumers.
// The bench drives sw_in through master; the debouncer serves the rest through slave.
interface switch_debouncer_if;
   logic [7:0] sw_in;
   logic [7:0] sw_out;
   logic [3:0] A;
   logic [3:0] B;
   logic       changed;
   logic       bouncing;

   modport master (
      output sw_in,
      input  sw_out,
      input  A,
      input  B,
      input  changed,
      input  bouncing
   );

   modport slave (
      input  sw_in,
      output sw_out,
      output A,
      output B,
      output changed,
      output bouncing
   );
endinterface

// File: rtl/switch_debouncer.sv
// 8-bit slide-switch debouncer: two-flop synchronizer followed by a whole-vector
// stability window of STABLE_COUNT cycles before the new value reaches sw_out.
module switch_debouncer #(
   parameter int STABLE_COUNT = 1000000,
   parameter int CNT_WIDTH    = 20
) (
   input logic               clock,
   input logic               reset_n,
   switch_debouncer_if.slave bus
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

   logic [7:0]           s1_q, s2_q;
   logic [7:0]           cand_q, cand_d;
   logic [7:0]           sw_out_q, sw_out_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 changed_q, changed_d;

   // A fresh candidate always wins; otherwise count toward acceptance only while
   // the candidate differs from the published value, so cnt never wraps.
   always_comb begin
      cand_d    = cand_q;
      sw_out_d  = sw_out_q;
      cnt_d     = '0;
      changed_d = 1'b0;
      if (s2_q != cand_q) begin
         cand_d = s2_q;
      end else if (cand_q != sw_out_q) begin
         if (cnt_q == CNT_LAST) begin
            sw_out_d  = cand_q;
            changed_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         s1_q      <= '0;
         s2_q      <= '0;
         cand_q    <= '0;
         sw_out_q  <= '0;
         cnt_q     <= '0;
         changed_q <= 1'b0;
      end else begin
         s1_q      <= bus.sw_in;
         s2_q      <= s1_q;
         cand_q    <= cand_d;
         sw_out_q  <= sw_out_d;
         cnt_q     <= cnt_d;
         changed_q <= changed_d;
      end
   end

   assign bus.sw_out   = sw_out_q;
   assign bus.A        = sw_out_q[3:0];
   assign bus.B        = sw_out_q[7:4];
   assign bus.changed  = changed_q;
   assign bus.bouncing = (cand_q != sw_out_q);

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer: a STABLE_COUNT=4 instance for the main
// scenarios and a STABLE_COUNT=1 instance for the minimum-window case.
module tb_switch_debouncer;

   logic clock = 1'b0;
   logic reset_n;
   logic reset2_n;
   int   tests = 0;
   int   fails = 0;
   int   pulses;
   logic saw_bounce;

   switch_debouncer_if bus ();
   switch_debouncer_if bus2 ();

   switch_debouncer #(.STABLE_COUNT(4), .CNT_WIDTH(3)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   switch_debouncer #(.STABLE_COUNT(1), .CNT_WIDTH(1)) dut2 (
      .clock   (clock),
      .reset_n (reset2_n),
      .bus     (bus2.slave)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag,
                          input logic [7:0] o_sw, input logic [3:0] o_a, input logic [3:0] o_b,
                          input logic o_chg, input logic o_bnc,
                          input logic [7:0] e_sw, input logic e_chg, input logic e_bnc);
      logic [7:0] e;
      e = e_sw;
      chk({tag, ".sw_out"}, o_sw, e);
      chk({tag, ".A"}, {4'h0, o_a}, {4'h0, e[3:0]});
      chk({tag, ".B"}, {4'h0, o_b}, {4'h0, e[7:4]});
      chk({tag, ".changed"}, {7'h0, o_chg}, {7'h0, e_chg});
      chk({tag, ".bouncing"}, {7'h0, o_bnc}, {7'h0, e_bnc});
   endtask

   initial begin
      // Reset held with all switches up
      reset_n    = 1'b0;
      reset2_n   = 1'b0;
      bus.sw_in  = 8'hFF;
      bus2.sw_in = 8'h00;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk_out($sformatf("rst%0d", i), bus.sw_out, bus.A, bus.B, bus.changed, bus.bouncing,
                 8'h00, 1'b0, 1'b0);
      end

      // Release with 8'h35: accepted on the 7th edge
      reset_n   = 1'b1;
      bus.sw_in = 8'h35;
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk_out($sformatf("rel%0d", i), bus.sw_out, bus.A, bus.B, bus.changed, bus.bouncing,
                 8'h00, 1'b0, (i >= 3));
      end
      tick();
      chk_out("rel7", bus.sw_out, bus.A, bus.B, bus.changed, bus.bouncing, 8'h35, 1'b1, 1'b0);
      tick();
      chk_out("rel8", bus.sw_out, bus.A, bus.B, bus.changed, bus.bouncing, 8'h35, 1'b0, 1'b0);

      // Two-cycle glitch to 8'h34 and back
      bus.sw_in = 8'h34;
      tick();
      tick();
      bus.sw_in = 8'h35;
      for (int i = 3; i <= 10; i++) begin
         tick();
         chk_out($sformatf("glitch%0d", i), bus.sw_out, bus.A, bus.B, bus.changed, bus.bouncing,
                 8'h35, 1'b0, (i <= 4));
      end

      // Settle at 8'h34 so bit 0 of sw_out is low
      bus.sw_in = 8'h34;
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk($sformatf("set34_%0d.sw_out", i), bus.sw_out, 8'h35);
      end
      tick();
      chk_out("set34_7", bus.sw_out, bus.A, bus.B, bus.changed, bus.bouncing, 8'h34, 1'b1, 1'b0);
      tick();
      tick();

      // Toggle bit 0 every 2 cycles for 20 cycles, ending low
      saw_bounce = 1'b0;
      pulses     = 0;
      for (int c = 0; c < 20; c++) begin
         bus.sw_in = (((c / 2) % 2) == 0) ? 8'h35 : 8'h34;
         tick();
         if (bus.bouncing) saw_bounce = 1'b1;
         if (bus.changed) pulses++;
         chk($sformatf("tog%0d.sw_out", c), bus.sw_out, 8'h34);
      end
      chk("tog.bouncing_seen", {7'h0, saw_bounce}, 8'h01);

      // Hold bit 0 high: accepted 7 edges after the final transition
      bus.sw_in = 8'h35;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (bus.changed) pulses++;
         chk($sformatf("hold%0d.sw_out", i), bus.sw_out, 8'h34);
      end
      tick();
      if (bus.changed) pulses++;
      chk_out("hold7", bus.sw_out, bus.A, bus.B, bus.changed, bus.bouncing, 8'h35, 1'b1, 1'b0);
      for (int i = 8; i <= 11; i++) begin
         tick();
         if (bus.changed) pulses++;
      end
      chk("hold.pulses", 8'(pulses), 8'd1);

      // Settle at 8'h00
      bus.sw_in = 8'h00;
      for (int i = 1; i <= 6; i++) tick();
      tick();
      chk_out("set00_7", bus.sw_out, bus.A, bus.B, bus.changed, bus.bouncing, 8'h00, 1'b1, 1'b0);
      tick();
      tick();

      // Step to 8'hA0, reset on edge 4 aborts the window
      bus.sw_in = 8'hA0;
      tick();
      tick();
      tick();
      chk_out("abort3", bus.sw_out, bus.A, bus.B, bus.changed, bus.bouncing, 8'h00, 1'b0, 1'b1);
      reset_n = 1'b0;
      tick();
      chk_out("abort4", bus.sw_out, bus.A, bus.B, bus.changed, bus.bouncing, 8'h00, 1'b0, 1'b0);
      reset_n = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk($sformatf("post%0d.sw_out", i), bus.sw_out, 8'h00);
         chk($sformatf("post%0d.changed", i), {7'h0, bus.changed}, 8'h00);
      end
      tick();
      chk_out("post7", bus.sw_out, bus.A, bus.B, bus.changed, bus.bouncing, 8'hA0, 1'b1, 1'b0);

      // Minimum window instance: 8'h00 -> 8'h0F lands on the 4th edge
      reset2_n = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk_out($sformatf("min_idle%0d", i), bus2.sw_out, bus2.A, bus2.B, bus2.changed,
                 bus2.bouncing, 8'h00, 1'b0, 1'b0);
      end
      bus2.sw_in = 8'h0F;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk_out($sformatf("min%0d", i), bus2.sw_out, bus2.A, bus2.B, bus2.changed,
                 bus2.bouncing, 8'h00, 1'b0, (i == 3));
      end
      tick();
      chk_out("min4", bus2.sw_out, bus2.A, bus2.B, bus2.changed, bus2.bouncing, 8'h0F, 1'b1, 1'b0);
      tick();
      chk_out("min5", bus2.sw_out, bus2.A, bus2.B, bus2.changed, bus2.bouncing, 8'h0F, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter STABLE_COUNT, default 1000000, is the number of consecutive clock cycles the synchronized input SHALL hold before being accepted (10 ms at 100 MHz); benches SHALL override it small.
REQ-002 Parameter CNT_WIDTH, default 20, is the stability counter width; STABLE_COUNT SHALL satisfy 1 <= STABLE_COUNT <= 2^CNT_WIDTH.
REQ-003 clock  input  1  100 MHz board clock; all state SHALL update on its rising edge only.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 sw_in  input  8  raw slide-switch vector, asynchronous to clock.
REQ-006 sw_out  output  8  debounced switch vector.
REQ-007 A  output  4  SHALL equal sw_out[3:0], for the math block and decoder.
REQ-008 B  output  4  SHALL equal sw_out[7:4], for the math block and decoder.
REQ-009 changed  output  1  single-cycle pulse marking an sw_out update.
REQ-010 bouncing  output  1  high while a candidate value differs from sw_out.

Function
REQ-011 sw_in SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-012 The block SHALL hold an 8-bit candidate register cand and a CNT_WIDTH-bit counter cnt.
REQ-013 Per cycle, priority 1: if s2 != cand, then cand <= s2 and cnt <= 0.
REQ-014 Priority 2: else if cand != sw_out and cnt == STABLE_COUNT-1, then sw_out <= cand, changed <= 1, and cnt <= 0.
REQ-015 Priority 3: else if cand != sw_out, then cnt <= cnt + 1.
REQ-016 Otherwise cnt <= 0.
REQ-017 changed SHALL be 0 in every cycle not covered by REQ-014; it SHALL be registered and high for exactly one cycle per update.
REQ-018 The whole vector SHALL be debounced as one unit: a change on any bit restarts the window for all bits.
REQ-019 Latency: a clean step on sw_in, first sampled at edge k, SHALL appear on sw_out and changed at edge k+2+STABLE_COUNT, i.e. STABLE_COUNT+3 edges inclusive.
REQ-020 A glitch that returns to the current sw_out value before the window completes SHALL reload cand to that value and SHALL NOT update sw_out or assert changed.
REQ-021 A new value arriving mid-window SHALL restart the window from 0 for the new value; the old candidate SHALL be discarded.
REQ-022 cnt SHALL never wrap; it is cleared on reaching STABLE_COUNT-1 and whenever cand == sw_out.
REQ-023 bouncing SHALL be combinational: (cand != sw_out).
REQ-024 A and B SHALL be combinational slices of sw_out, with no added latency.

Reset
REQ-025 While reset_n is low at a rising edge, s1, s2, cand, cnt, sw_out and changed SHALL all load 0; A, B and bouncing therefore read 0.
REQ-026 Reset asserted mid-window SHALL abort the window; no partial update SHALL occur.
REQ-027 After release, a nonzero sw_in SHALL be debounced as a fresh change per REQ-019, counting from the first post-release edge.
REQ-028 The block SHALL have no asynchronous reset path.

Verification (STABLE_COUNT=4, CNT_WIDTH=3 unless stated)
REQ-029 Hold reset_n=0 with sw_in=8'hFF for 5 edges: sw_out=8'h00, A=0, B=0, changed=0, bouncing=0 throughout.
REQ-030 Release reset with sw_in=8'h35 held: sw_out=8'h35, A=4'h5, B=4'h3 on the 7th edge after release; changed high for exactly that cycle.
REQ-031 Toggle sw_in[0] every 2 cycles for 20 cycles, then hold at 1: sw_out unchanged and bouncing=1 during toggling; sw_out[0]=1 exactly 7 edges after the final transition; one changed pulse.
REQ-032 From stable 8'h35, drive 8'h34 for 2 cycles, then back to 8'h35: sw_out stays 8'h35, changed never asserts, and bouncing returns to 0.
REQ-033 From stable 8'h00, step sw_in to 8'hA0, then assert reset_n=0 for 1 edge at edge 4: sw_out=0; after release, sw_out=8'hA0 on the 7th post-release edge.
REQ-034 With STABLE_COUNT=1, step sw_in 8'h00->8'h0F: sw_out=8'h0F on the 4th edge with a single changed pulse.
